// File: rtl/mem_access_stage.sv
// Memory-access stage: data-cache handshake for loads/stores, load alignment and
// extension, register-file writeback, and execute stall while a cache access is pending.
module mem_access_stage #(
    parameter int RD_W = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EX_VALID,
    input  logic [31:0]     EX_WB_DATA,
    input  logic [31:0]     EX_ADDR,
    input  logic [1:0]      EX_CACHE_CNT,
    input  logic [2:0]      EX_FUN3,
    input  logic [31:0]     EX_STORE_DATA,
    input  logic [RD_W-1:0] EX_RD,
    input  logic            FLUSH,
    output logic            DC_REQ,
    output logic            DC_WE,
    output logic [31:0]     DC_ADDR,
    output logic [3:0]      DC_WSTRB,
    output logic [31:0]     DC_WDATA,
    input  logic [31:0]     DC_RDATA,
    input  logic            DC_READY,
    output logic            STALL,
    output logic            RF_WE,
    output logic [RD_W-1:0] RF_RD,
    output logic [31:0]     RF_DATA,
    output logic            MISALIGNED
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t          r_state, w_next_state;
    logic            r_dc_req, r_dc_we;
    logic [31:0]     r_dc_addr, r_dc_wdata;
    logic [3:0]      r_dc_wstrb;
    logic [2:0]      r_ld_fun3;
    logic [1:0]      r_ld_off;
    logic [RD_W-1:0] r_ld_rd;
    logic            r_rf_we, r_misaligned;
    logic [RD_W-1:0] r_rf_rd;
    logic [31:0]     r_rf_data;
    logic            r_hold_vld;
    logic [RD_W-1:0] r_hold_rd;
    logic [31:0]     r_hold_data;

    logic            w_accept, w_is_load, w_is_store, w_is_mem;
    logic            w_bad_fun3, w_bad_align, w_illegal, w_mem_go, w_done;
    logic            w_ld_wb, w_alu_wb;
    logic [31:0]     w_ld_data;
    logic [3:0]      w_wstrb;
    logic [31:0]     w_wdata;
    logic            w_wb_vld, w_hold_vld_n;
    logic [RD_W-1:0] w_wb_rd, w_hold_rd_n;
    logic [31:0]     w_wb_data, w_hold_data_n;

    function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                               input logic [2:0]  fun3,
                                               input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*off +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (fun3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign STALL      = (r_state == ACCESS) & ~DC_READY;
    assign w_accept   = EX_VALID & ~FLUSH & ~STALL;
    assign w_is_load  = (EX_CACHE_CNT == 2'b01);
    assign w_is_store = (EX_CACHE_CNT == 2'b10);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_done     = (r_state == ACCESS) & DC_READY;

    assign w_bad_fun3  = w_is_load ? ((EX_FUN3 == 3'b011) || (EX_FUN3[2:1] == 2'b11))
                                   : (EX_FUN3[2] || (EX_FUN3[1:0] == 2'b11));
    assign w_bad_align = ((EX_FUN3[1:0] == 2'b01) && EX_ADDR[0]) ||
                         ((EX_FUN3[1:0] == 2'b10) && (EX_ADDR[1:0] != 2'b00));
    assign w_illegal   = w_bad_fun3 | w_bad_align;
    assign w_mem_go    = w_accept & w_is_mem & ~w_illegal;

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = EX_STORE_DATA;
        case (EX_FUN3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << EX_ADDR[1:0];
                w_wdata = {4{EX_STORE_DATA[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << EX_ADDR[1:0];
                w_wdata = {2{EX_STORE_DATA[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_mem_go) w_next_state = ACCESS;
            ACCESS:  if (DC_READY) w_next_state = w_mem_go ? ACCESS : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_ld_data = load_align(DC_RDATA, r_ld_fun3, r_ld_off);
    assign w_ld_wb   = w_done & ~r_dc_we & (r_ld_rd != '0);
    assign w_alu_wb  = w_accept & ~w_is_mem & (EX_RD != '0);

    // A load completing on the same edge as a younger ALU op wins the single
    // write port; the ALU result waits one cycle in the hold slot, keeping order.
    always_comb begin
        w_wb_vld      = 1'b0;
        w_wb_rd       = r_rf_rd;
        w_wb_data     = r_rf_data;
        w_hold_vld_n  = 1'b0;
        w_hold_rd_n   = r_hold_rd;
        w_hold_data_n = r_hold_data;
        if (r_hold_vld) begin
            w_wb_vld  = 1'b1;
            w_wb_rd   = r_hold_rd;
            w_wb_data = r_hold_data;
            if (w_alu_wb) begin
                w_hold_vld_n  = 1'b1;
                w_hold_rd_n   = EX_RD;
                w_hold_data_n = EX_WB_DATA;
            end
        end else if (w_ld_wb) begin
            w_wb_vld  = 1'b1;
            w_wb_rd   = r_ld_rd;
            w_wb_data = w_ld_data;
            if (w_alu_wb) begin
                w_hold_vld_n  = 1'b1;
                w_hold_rd_n   = EX_RD;
                w_hold_data_n = EX_WB_DATA;
            end
        end else if (w_alu_wb) begin
            w_wb_vld  = 1'b1;
            w_wb_rd   = EX_RD;
            w_wb_data = EX_WB_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_dc_req     <= 1'b0;
            r_dc_we      <= 1'b0;
            r_dc_addr    <= '0;
            r_dc_wstrb   <= '0;
            r_dc_wdata   <= '0;
            r_ld_fun3    <= '0;
            r_ld_off     <= '0;
            r_ld_rd      <= '0;
            r_rf_we      <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_data    <= '0;
            r_misaligned <= 1'b0;
            r_hold_vld   <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_rf_we      <= w_wb_vld;
            r_rf_rd      <= w_wb_rd;
            r_rf_data    <= w_wb_data;
            r_hold_vld   <= w_hold_vld_n;
            r_hold_rd    <= w_hold_rd_n;
            r_hold_data  <= w_hold_data_n;
            r_misaligned <= w_accept & w_is_mem & w_illegal;
            if (w_mem_go) begin
                r_dc_req   <= 1'b1;
                r_dc_we    <= w_is_store;
                r_dc_addr  <= {EX_ADDR[31:2], 2'b00};
                r_dc_wstrb <= w_is_store ? w_wstrb : 4'b0000;
                r_dc_wdata <= w_is_store ? w_wdata : 32'd0;
                r_ld_fun3  <= EX_FUN3;
                r_ld_off   <= EX_ADDR[1:0];
                r_ld_rd    <= EX_RD;
            end else if (w_done) begin
                r_dc_req <= 1'b0;
            end
        end
    end

    assign DC_REQ     = r_dc_req;
    assign DC_WE      = r_dc_we;
    assign DC_ADDR    = r_dc_addr;
    assign DC_WSTRB   = r_dc_wstrb;
    assign DC_WDATA   = r_dc_wdata;
    assign RF_WE      = r_rf_we;
    assign RF_RD      = r_rf_rd;
    assign RF_DATA    = r_rf_data;
    assign MISALIGNED = r_misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: transaction-level model checked every cycle,
// plus hand-computed literal checks at key points of each scenario.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EX_VALID = 1'b0;
    logic [31:0] EX_WB_DATA = '0;
    logic [31:0] EX_ADDR = '0;
    logic [1:0]  EX_CACHE_CNT = '0;
    logic [2:0]  EX_FUN3 = '0;
    logic [31:0] EX_STORE_DATA = '0;
    logic [4:0]  EX_RD = '0;
    logic        FLUSH = 1'b0;
    logic        DC_REQ, DC_WE;
    logic [31:0] DC_ADDR, DC_WDATA;
    logic [3:0]  DC_WSTRB;
    logic [31:0] DC_RDATA = '0;
    logic        DC_READY = 1'b0;
    logic        STALL, RF_WE, MISALIGNED;
    logic [4:0]  RF_RD;
    logic [31:0] RF_DATA;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.RD_W(5)) dut (
        .CLK(CLK), .RST(RST), .EX_VALID(EX_VALID), .EX_WB_DATA(EX_WB_DATA),
        .EX_ADDR(EX_ADDR), .EX_CACHE_CNT(EX_CACHE_CNT), .EX_FUN3(EX_FUN3),
        .EX_STORE_DATA(EX_STORE_DATA), .EX_RD(EX_RD), .FLUSH(FLUSH),
        .DC_REQ(DC_REQ), .DC_WE(DC_WE), .DC_ADDR(DC_ADDR), .DC_WSTRB(DC_WSTRB),
        .DC_WDATA(DC_WDATA), .DC_RDATA(DC_RDATA), .DC_READY(DC_READY),
        .STALL(STALL), .RF_WE(RF_WE), .RF_RD(RF_RD), .RF_DATA(RF_DATA),
        .MISALIGNED(MISALIGNED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         m_q[$];
    wb_t         m_wb;
    bit          m_busy = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_strb = '0;
    logic [2:0]  m_f3 = '0;
    logic [1:0]  m_off = '0;
    logic [4:0]  m_rd = '0;
    bit          e_rf_we = 0, e_mis = 0;
    logic [4:0]  e_rf_rd = '0;
    logic [31:0] e_rf_data = '0;
    bit          m_stall, m_acc;

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_legal(input bit load, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (load) ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else      ok = (f3 == 0 || f3 == 1 || f3 == 2);
        return ok && ((a % acc_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] mk_strb(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = (1 << acc_size(f3)) - 1;
        return 4'(m << (a % 4));
    endfunction

    function automatic logic [31:0] mk_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = acc_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] mk_load(input logic [31:0] rd, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] v;
        int sz, sh;
        sz = acc_size(f3);
        if (sz == 4) return rd;
        sh = 32 - 8 * sz;
        v  = (rd >> (8 * off)) << sh;
        if (!f3[2]) return $signed(v) >>> sh;
        return v >> sh;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q.delete();
            m_busy = 0; m_we = 0;
            e_rf_we = 0; e_mis = 0;
        end else begin
            m_stall = m_busy && !DC_READY;
            m_acc   = EX_VALID && !FLUSH && !m_stall;
            e_mis   = 0;
            if (m_busy && DC_READY) begin
                if (!m_we && m_rd != 0) m_q.push_back('{m_rd, mk_load(DC_RDATA, m_f3, m_off)});
                m_busy = 0;
            end
            if (m_acc) begin
                if (EX_CACHE_CNT == 2'b01 || EX_CACHE_CNT == 2'b10) begin
                    if (is_legal(EX_CACHE_CNT == 2'b01, EX_FUN3, EX_ADDR)) begin
                        m_busy  = 1;
                        m_we    = (EX_CACHE_CNT == 2'b10);
                        m_addr  = EX_ADDR & ~32'h3;
                        m_strb  = mk_strb(EX_FUN3, EX_ADDR);
                        m_wdata = mk_wdata(EX_FUN3, EX_STORE_DATA);
                        m_f3    = EX_FUN3;
                        m_off   = EX_ADDR[1:0];
                        m_rd    = EX_RD;
                    end else begin
                        e_mis = 1;
                    end
                end else if (EX_RD != 0) begin
                    m_q.push_back('{EX_RD, EX_WB_DATA});
                end
            end
            if (m_q.size() > 0) begin
                m_wb      = m_q.pop_front();
                e_rf_we   = 1;
                e_rf_rd   = m_wb.rd;
                e_rf_data = m_wb.data;
            end else begin
                e_rf_we = 0;
            end
        end
    end

    always @(negedge CLK) begin
        chk("stall", 32'(STALL), 32'(m_busy && !DC_READY));
        chk("dc_req", 32'(DC_REQ), 32'(m_busy));
        chk("rf_we", 32'(RF_WE), 32'(e_rf_we));
        chk("misaligned", 32'(MISALIGNED), 32'(e_mis));
        if (e_rf_we) begin
            chk("rf_rd", 32'(RF_RD), 32'(e_rf_rd));
            chk("rf_data", RF_DATA, e_rf_data);
        end
        if (m_busy) begin
            chk("dc_we", 32'(DC_WE), 32'(m_we));
            chk("dc_addr", DC_ADDR, m_addr);
            if (m_we) begin
                chk("dc_wstrb", 32'(DC_WSTRB), 32'(m_strb));
                chk("dc_wdata", DC_WDATA, m_wdata);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ex(input logic [1:0] cnt, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] sd, input logic [31:0] wb, input logic [4:0] rd);
        EX_VALID      = 1'b1;
        EX_CACHE_CNT  = cnt;
        EX_FUN3       = f3;
        EX_ADDR       = addr;
        EX_STORE_DATA = sd;
        EX_WB_DATA    = wb;
        EX_RD         = rd;
    endtask

    task automatic ex_clr();
        EX_VALID = 1'b0;
        FLUSH    = 1'b0;
    endtask

    int stall_cnt;

    initial begin
        step();
        step();
        RST = 1'b0;
        chk("reset dc_req", 32'(DC_REQ), 32'd0);
        chk("reset rf_we", 32'(RF_WE), 32'd0);
        chk("reset stall", 32'(STALL), 32'd0);
        chk("reset misaligned", 32'(MISALIGNED), 32'd0);

        // ALU op rd=5, then rd=0, then back-to-back ALU ops
        ex(2'b00, 3'b000, 32'h0, 32'h0, 32'h0000_1234, 5'd5);
        step();
        ex_clr();
        chk("alu rf_we", 32'(RF_WE), 32'd1);
        chk("alu rf_rd", 32'(RF_RD), 32'd5);
        chk("alu rf_data", RF_DATA, 32'h0000_1234);
        ex(2'b00, 3'b000, 32'h0, 32'h0, 32'h0000_9999, 5'd0);
        step();
        ex_clr();
        chk("alu rd0 rf_we", 32'(RF_WE), 32'd0);
        ex(2'b11, 3'b010, 32'h0, 32'h0, 32'h1111_1111, 5'd1);
        step();
        ex(2'b00, 3'b000, 32'h0, 32'h0, 32'h2222_2222, 5'd2);
        step();
        ex_clr();
        chk("b2b alu rf_data", RF_DATA, 32'h2222_2222);
        step();

        // LB 0x1003 with DC_READY after 3 stall cycles
        ex(2'b01, 3'b000, 32'h0000_1003, 32'h0, 32'h0, 5'd7);
        step();
        ex_clr();
        chk("lb dc_addr", DC_ADDR, 32'h0000_1000);
        chk("lb dc_req", 32'(DC_REQ), 32'd1);
        chk("lb dc_we", 32'(DC_WE), 32'd0);
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (STALL) stall_cnt++;
            step();
        end
        DC_READY = 1'b1;
        DC_RDATA = 32'h80FF_0000;
        @(negedge CLK);
        chk("lb ready stall", 32'(STALL), 32'd0);
        step();
        DC_READY = 1'b0;
        chk("lb stall cycles", 32'(stall_cnt), 32'd3);
        chk("lb rf_we", 32'(RF_WE), 32'd1);
        chk("lb rf_rd", 32'(RF_RD), 32'd7);
        chk("lb rf_data", RF_DATA, 32'hFFFF_FF80);
        chk("lb dc_req drop", 32'(DC_REQ), 32'd0);

        // LBU 0x1003 with immediate ready
        ex(2'b01, 3'b100, 32'h0000_1003, 32'h0, 32'h0, 5'd8);
        step();
        ex_clr();
        DC_READY = 1'b1;
        step();
        DC_READY = 1'b0;
        chk("lbu rf_data", RF_DATA, 32'h0000_0080);

        // LH 0x1002 completing while LHU 0x1000 is accepted back-to-back
        DC_RDATA = 32'h8001_F00D;
        ex(2'b01, 3'b001, 32'h0000_1002, 32'h0, 32'h0, 5'd10);
        step();
        ex(2'b01, 3'b101, 32'h0000_1000, 32'h0, 32'h0, 5'd11);
        DC_READY = 1'b1;
        step();
        ex_clr();
        chk("lh rf_data", RF_DATA, 32'hFFFF_8001);
        chk("lhu dc_req", 32'(DC_REQ), 32'd1);
        step();
        DC_READY = 1'b0;
        chk("lhu rf_data", RF_DATA, 32'h0000_F00D);

        // SH 0x2002, held one cycle, ALU accepted back-to-back on completion
        ex(2'b10, 3'b001, 32'h0000_2002, 32'hABCD_1234, 32'h0, 5'd3);
        step();
        ex_clr();
        chk("sh dc_we", 32'(DC_WE), 32'd1);
        chk("sh dc_wstrb", 32'(DC_WSTRB), 32'b1100);
        chk("sh dc_wdata", DC_WDATA, 32'h1234_1234);
        chk("sh dc_addr", DC_ADDR, 32'h0000_2000);
        step();
        DC_READY = 1'b1;
        ex(2'b00, 3'b000, 32'h0, 32'h0, 32'h0000_0055, 5'd9);
        step();
        ex_clr();
        DC_READY = 1'b0;
        chk("sh then alu rf_rd", 32'(RF_RD), 32'd9);
        chk("sh dc_req drop", 32'(DC_REQ), 32'd0);

        // SB 0x2001 and SW 0x2004
        ex(2'b10, 3'b000, 32'h0000_2001, 32'h0000_00A5, 32'h0, 5'd0);
        step();
        ex_clr();
        chk("sb dc_wstrb", 32'(DC_WSTRB), 32'b0010);
        chk("sb dc_wdata", DC_WDATA, 32'hA5A5_A5A5);
        DC_READY = 1'b1;
        step();
        DC_READY = 1'b0;
        ex(2'b10, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 5'd0);
        step();
        ex_clr();
        chk("sw dc_wstrb", 32'(DC_WSTRB), 32'b1111);
        DC_READY = 1'b1;
        step();
        DC_READY = 1'b0;

        // Misaligned / illegal accesses
        ex(2'b01, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 5'd4);
        step();
        ex_clr();
        chk("lw mis pulse", 32'(MISALIGNED), 32'd1);
        chk("lw mis dc_req", 32'(DC_REQ), 32'd0);
        chk("lw mis stall", 32'(STALL), 32'd0);
        step();
        chk("lw mis pulse end", 32'(MISALIGNED), 32'd0);
        chk("lw mis rf_we", 32'(RF_WE), 32'd0);
        ex(2'b10, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 5'd0);
        step();
        ex(2'b01, 3'b110, 32'h0000_3000, 32'h0, 32'h0, 5'd4);
        step();
        ex(2'b01, 3'b101, 32'h0000_3003, 32'h0, 32'h0, 5'd4);
        step();
        ex_clr();
        chk("lhu odd mis", 32'(MISALIGNED), 32'd1);
        step();

        // FLUSH drops a valid op; FLUSH during ACCESS does not touch the in-flight load
        ex(2'b00, 3'b000, 32'h0, 32'h0, 32'h0000_7777, 5'd3);
        FLUSH = 1'b1;
        step();
        ex_clr();
        chk("flush rf_we", 32'(RF_WE), 32'd0);
        ex(2'b01, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 5'd12);
        step();
        ex(2'b00, 3'b000, 32'h0, 32'h0, 32'h0000_0001, 5'd13);
        FLUSH    = 1'b1;
        DC_READY = 1'b1;
        DC_RDATA = 32'hDEAD_BEEF;
        step();
        ex_clr();
        DC_READY = 1'b0;
        chk("flush inflight rf_rd", 32'(RF_RD), 32'd12);
        chk("flush inflight rf_data", RF_DATA, 32'hDEAD_BEEF);
        step();
        chk("flushed op no wb", 32'(RF_WE), 32'd0);

        // Reset in the middle of an access
        ex(2'b01, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 5'd14);
        step();
        ex_clr();
        #2;
        RST = 1'b1;
        #1;
        chk("rst dc_req", 32'(DC_REQ), 32'd0);
        chk("rst stall", 32'(STALL), 32'd0);
        chk("rst rf_we", 32'(RF_WE), 32'd0);
        step();
        RST = 1'b0;
        ex(2'b00, 3'b000, 32'h0, 32'h0, 32'h0000_CAFE, 5'd6);
        step();
        ex_clr();
        chk("post rst rf_rd", 32'(RF_RD), 32'd6);
        chk("post rst rf_data", RF_DATA, 32'h0000_CAFE);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage directly downstream of the execute stage. It captures the execute result, load/store control and data address each cycle, performs the data-cache handshake for loads and stores, aligns and extends load data, and drives the register-file write port. It stalls execute while a cache access is outstanding.

## Interface
- RD_W, 5, register destination index width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- EX_VALID  in  1  execute result valid this cycle
- EX_WB_DATA  in  32  ALU/CSR result for non-memory ops
- EX_ADDR  in  32  data address (A+B from execute)
- EX_CACHE_CNT  in  2  00 none, 01 load, 10 store, 11 treated as none
- EX_FUN3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- EX_STORE_DATA  in  32  rs2 value for stores
- EX_RD  in  RD_W  destination register
- FLUSH  in  1  discard the execute result presented this cycle
- DC_REQ  out  1  cache request, held until DC_READY
- DC_WE  out  1  1 = store
- DC_ADDR  out  32  word-aligned address {addr[31:2],2'b00}
- DC_WSTRB  out  4  byte enables
- DC_WDATA  out  32  replicated store data
- DC_RDATA  in  32  read word, valid when DC_READY
- DC_READY  in  1  request completed this cycle
- STALL  out  1  execute must hold its outputs
- RF_WE  out  1  register write enable
- RF_RD  out  RD_W  write index
- RF_DATA  out  32  write data
- MISALIGNED  out  1  one-cycle pulse, illegal access dropped

## Operation
- States: IDLE, ACCESS. Reset: IDLE; all outputs 0.
- Accept condition: EX_VALID & !FLUSH & !STALL at a rising edge. FLUSH never affects an access already in ACCESS (the in-flight instruction is older than the flush source).
- Non-memory op accepted: RF_WE = (EX_RD != 0), RF_RD/RF_DATA = EX_RD/EX_WB_DATA next cycle; stay IDLE.
- Misaligned check: H/HU with addr[0]=1, W with addr[1:0]!=0, load fun3 in {011,110,111}, store fun3 not in {000,001,010}: no request, no RF write, MISALIGNED=1 next cycle, stay IDLE.
- Legal load/store accepted: go ACCESS; DC_REQ=1, DC_WE, DC_ADDR, DC_WSTRB, DC_WDATA registered and held stable until DC_READY.
- Store strobes: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111. WDATA: B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
- Load extract: byte = RDATA[8*addr[1:0]+:8], half = RDATA[16*addr[1]+:16]; B/H sign-extend, BU/HU zero-extend, W unchanged.
- ACCESS with DC_READY=1: DC_REQ drops next cycle; load writes RF next cycle (suppressed if rd=0); store writes nothing; return IDLE.
- STALL = (state==ACCESS) & !DC_READY (combinational). In the DC_READY cycle STALL=0 and a new EX op may be accepted on the same edge (back-to-back); its request/writeback follows normally.
- RF_WE and MISALIGNED are single-cycle pulses; deasserted in any cycle without a completing op.
- RST mid-ACCESS: immediately IDLE, DC_REQ=0, pending writeback lost.

## Timing
- Non-memory op: accepted edge N, RF_WE high cycle N..N+1 (1-cycle latency).
- Load: accepted edge N, DC_REQ high from N+1; DC_READY sampled high at edge M, RF_WE high cycle after M. Minimum load-to-writeback 2 cycles.
- Store: same request timing, completion at DC_READY edge, no RF write.
- DC_REQ never deasserts before DC_READY; DC_* outputs change only on acceptance.
- Throughput: one non-memory op per cycle; one memory op per DC_READY.

## Test plan
- ALU op, EX_RD=5, EX_WB_DATA=0x1234 -> RF_WE=1, RF_RD=5, RF_DATA=0x1234 one cycle later; EX_RD=0 -> RF_WE=0.
- LB addr 0x1003, DC_RDATA=0x80FF_0000 with DC_READY after 3 cycles -> STALL high 3 cycles, DC_ADDR=0x1000, RF_DATA=0xFFFF_FF80; LBU -> 0x0000_0080.
- SH addr 0x2002, data 0xABCD_1234 -> DC_WE=1, DC_WSTRB=4'b1100, DC_WDATA=0x1234_1234, no RF write.
- LW addr 0x3001 -> MISALIGNED pulse, DC_REQ stays 0, no RF write, STALL stays 0.
- FLUSH with EX_VALID -> nothing accepted; FLUSH during ACCESS -> in-flight load still writes back.
- RST asserted mid-ACCESS -> DC_REQ, STALL, RF_WE drop immediately; next ALU op writes back normally.
